// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the decode-to-execute register and the vector ALU.
// Holds opcodes, func codes, lane-width (WW) and byte-participation (PPP)
// encodings, the instruction field layout and the PPP-to-byte-mask decoder.
// Numbering is big-endian: bit 0 is the MSB, byte 0 is bits [0:7].
package id_ex_stage_pkg;

    // Opcodes
    localparam logic [5:0] OpRtype = 6'b101010;
    localparam logic [5:0] OpVld   = 6'b100000;

    // R-type func codes (range VAND..VSQRT)
    localparam logic [5:0] FnNop   = 6'b000000;
    localparam logic [5:0] FnVand  = 6'b000001;
    localparam logic [5:0] FnVadd  = 6'b000110;
    localparam logic [5:0] FnVsqrt = 6'b010010;

    // Lane width encodings
    localparam logic [1:0] Ww8  = 2'b00;
    localparam logic [1:0] Ww16 = 2'b01;
    localparam logic [1:0] Ww32 = 2'b10;
    localparam logic [1:0] Ww64 = 2'b11;

    // Byte-participation encodings; 101..111 select no bytes
    localparam logic [2:0] PppAll   = 3'b000;
    localparam logic [2:0] PppUpper = 3'b001;
    localparam logic [2:0] PppLower = 3'b010;
    localparam logic [2:0] PppEven  = 3'b011;
    localparam logic [2:0] PppOdd   = 3'b100;

    // Instruction layout; first member lands on instruction bit 0 (MSB).
    typedef struct packed {
        logic [5:0] opcode;  // [0:5]
        logic [4:0] rd;      // [6:10]
        logic [4:0] ra;      // [11:15]
        logic [4:0] rb;      // [16:20]
        logic [2:0] ppp;     // [21:23]
        logic [1:0] ww;      // [24:25]
        logic [5:0] func;    // [26:31]
    } instr_t;

    // Per-byte enable; mask[i] enables byte i (byte 0 = most significant).
    function automatic logic [0:7] ppp_byte_mask(input logic [0:2] ppp);
        logic [0:7] mask;
        case (ppp)
            PppAll:   mask = 8'b1111_1111;
            PppUpper: mask = 8'b1111_0000;
            PppLower: mask = 8'b0000_1111;
            PppEven:  mask = 8'b1010_1010;
            PppOdd:   mask = 8'b0101_0101;
            default:  mask = 8'b0000_0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ppp_byte_merge.sv
// Combinational byte merge of a write-back word into a base operand.
// Ports:
//   base   - operand as read from the register file (or currently held)
//   wb     - write-back data
//   ppp    - write-back byte-participation field
//   hit    - write-back targets this operand's register
//   merged - base with every PPP-enabled byte replaced by wb when hit
module ppp_byte_merge
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [0:DATA_W-1] base,
    input  logic [0:DATA_W-1] wb,
    input  logic [0:2]        ppp,
    input  logic              hit,
    output logic [0:DATA_W-1] merged
);

    logic [0:7] mask;

    always_comb begin
        mask   = ppp_byte_mask(ppp);
        merged = base;
        for (int i = 0; i < 8; i++) begin
            if (hit && mask[i]) begin
                merged[i*8 +: 8] = wb[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register for the 64-bit vector datapath.
// Captures one decoded instruction per cycle, forwards same-cycle write-back
// data into the operands byte by byte, and supports stall and flush.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   id_valid, id_instr         - decode slot valid and instruction
//   id_rA_data, id_rB_data     - register-file read data
//   wb_reg_wr, wb_rd_addr,
//   wb_ppp, wb_data            - write-back port (forwarding source)
//   stall, flush               - hazard-unit controls
//   rA_64bit_val, rB_64bit_val - ALU operands
//   Op_code, R_ins, WW         - ALU control fields
//   ex_rd_addr, ex_ppp         - destination info toward write-back
//   ex_rA_addr, ex_rB_addr     - held source addresses
//   ex_reg_wr, ex_valid        - EX writes the register file / holds a real op
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [0:31]       id_instr,
    input  logic [0:DATA_W-1] id_rA_data,
    input  logic [0:DATA_W-1] id_rB_data,
    input  logic              wb_reg_wr,
    input  logic [0:ADDR_W-1] wb_rd_addr,
    input  logic [0:2]        wb_ppp,
    input  logic [0:DATA_W-1] wb_data,
    input  logic              stall,
    input  logic              flush,
    output logic [0:DATA_W-1] rA_64bit_val,
    output logic [0:DATA_W-1] rB_64bit_val,
    output logic [0:5]        Op_code,
    output logic [0:5]        R_ins,
    output logic [0:1]        WW,
    output logic [0:ADDR_W-1] ex_rd_addr,
    output logic [0:2]        ex_ppp,
    output logic [0:ADDR_W-1] ex_rA_addr,
    output logic [0:ADDR_W-1] ex_rB_addr,
    output logic              ex_reg_wr,
    output logic              ex_valid
);

    instr_t            instr;
    logic              ld_hit_a, ld_hit_b, st_hit_a, st_hit_b;
    logic              wr_en;
    logic [0:DATA_W-1] ld_a, ld_b, st_a, st_b;

    assign instr = instr_t'(id_instr);

    // Load-time hits compare against decode sources; stall-time hits against
    // the held sources so a write-back landing mid-stall is not lost.
    assign ld_hit_a = wb_reg_wr && (wb_rd_addr == instr.ra);
    assign ld_hit_b = wb_reg_wr && (wb_rd_addr == instr.rb);
    assign st_hit_a = wb_reg_wr && (wb_rd_addr == ex_rA_addr);
    assign st_hit_b = wb_reg_wr && (wb_rd_addr == ex_rB_addr);

    assign wr_en = ((instr.opcode == OpRtype) && (instr.func != FnNop)) ||
                   (instr.opcode == OpVld);

    ppp_byte_merge #(.DATA_W(DATA_W)) u_ld_a (
        .base(id_rA_data), .wb(wb_data), .ppp(wb_ppp), .hit(ld_hit_a), .merged(ld_a)
    );
    ppp_byte_merge #(.DATA_W(DATA_W)) u_ld_b (
        .base(id_rB_data), .wb(wb_data), .ppp(wb_ppp), .hit(ld_hit_b), .merged(ld_b)
    );
    ppp_byte_merge #(.DATA_W(DATA_W)) u_st_a (
        .base(rA_64bit_val), .wb(wb_data), .ppp(wb_ppp), .hit(st_hit_a), .merged(st_a)
    );
    ppp_byte_merge #(.DATA_W(DATA_W)) u_st_b (
        .base(rB_64bit_val), .wb(wb_data), .ppp(wb_ppp), .hit(st_hit_b), .merged(st_b)
    );

    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && !id_valid)) begin
            // Reset, flush and an invalid decode slot all yield a bubble.
            rA_64bit_val <= '0;
            rB_64bit_val <= '0;
            Op_code      <= '0;
            R_ins        <= '0;
            WW           <= '0;
            ex_rd_addr   <= '0;
            ex_ppp       <= '0;
            ex_rA_addr   <= '0;
            ex_rB_addr   <= '0;
            ex_reg_wr    <= 1'b0;
            ex_valid     <= 1'b0;
        end else if (stall) begin
            rA_64bit_val <= st_a;
            rB_64bit_val <= st_b;
        end else begin
            rA_64bit_val <= ld_a;
            rB_64bit_val <= ld_b;
            Op_code      <= instr.opcode;
            R_ins        <= instr.func;
            WW           <= instr.ww;
            ex_rd_addr   <= instr.rd;
            ex_ppp       <= instr.ppp;
            ex_rA_addr   <= instr.ra;
            ex_rB_addr   <= instr.rb;
            ex_reg_wr    <= wr_en;
            ex_valid     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases then random traffic,
// with a queue-based scoreboard fed by a behavioural model of the EX register.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, id_valid, wb_reg_wr, stall, flush;
    logic [0:31] id_instr;
    logic [0:63] id_rA_data, id_rB_data, wb_data;
    logic [0:4]  wb_rd_addr;
    logic [0:2]  wb_ppp;
    logic [0:63] rA_64bit_val, rB_64bit_val;
    logic [0:5]  Op_code, R_ins;
    logic [0:1]  WW;
    logic [0:4]  ex_rd_addr, ex_rA_addr, ex_rB_addr;
    logic [0:2]  ex_ppp;
    logic        ex_reg_wr, ex_valid;

    // Instruction fields as the bench chose them (numeric values).
    logic [5:0] f_op, f_fn;
    logic [4:0] f_rd, f_ra, f_rb;
    logic [2:0] f_ppp;
    logic [1:0] f_ww;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] a, b;
        logic [5:0]  op, fn;
        logic [1:0]  ww;
        logic [4:0]  rd, ra, rb;
        logic [2:0]  ppp;
        logic        wr, valid;
    } ex_t;

    ex_t m;           // model of current EX contents
    ex_t exp_q[$];
    ex_t e;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .id_rA_data(id_rA_data), .id_rB_data(id_rB_data),
        .wb_reg_wr(wb_reg_wr), .wb_rd_addr(wb_rd_addr), .wb_ppp(wb_ppp), .wb_data(wb_data),
        .stall(stall), .flush(flush),
        .rA_64bit_val(rA_64bit_val), .rB_64bit_val(rB_64bit_val),
        .Op_code(Op_code), .R_ins(R_ins), .WW(WW),
        .ex_rd_addr(ex_rd_addr), .ex_ppp(ex_ppp),
        .ex_rA_addr(ex_rA_addr), .ex_rB_addr(ex_rB_addr),
        .ex_reg_wr(ex_reg_wr), .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    function automatic ex_t bubble();
        ex_t z;
        z.a = '0; z.b = '0; z.op = '0; z.fn = '0; z.ww = '0;
        z.rd = '0; z.ra = '0; z.rb = '0; z.ppp = '0; z.wr = 1'b0; z.valid = 1'b0;
        return z;
    endfunction

    // Does PPP include byte k (k = 0 is the most significant byte)?
    function automatic bit byte_on(input logic [2:0] ppp, input int k);
        case (ppp)
            3'd0:    return 1'b1;
            3'd1:    return k < 4;
            3'd2:    return k >= 4;
            3'd3:    return (k % 2) == 0;
            3'd4:    return (k % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] fwd(input logic [63:0] base, input logic [4:0] addr);
        logic [63:0] r, bm;
        r = base;
        if (wb_reg_wr && wb_rd_addr == addr) begin
            for (int k = 0; k < 8; k++) begin
                if (byte_on(wb_ppp, k)) begin
                    bm = 64'hFF << (56 - 8 * k);
                    r  = (r & ~bm) | (64'(wb_data) & bm);
                end
            end
        end
        return r;
    endfunction

    task automatic set_instr(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] ra,
                             input logic [4:0] rb, input logic [2:0] ppp, input logic [1:0] ww,
                             input logic [5:0] fn);
        f_op = op; f_rd = rd; f_ra = ra; f_rb = rb; f_ppp = ppp; f_ww = ww; f_fn = fn;
        id_instr = {op, rd, ra, rb, ppp, ww, fn};
    endtask

    // Predict the EX contents after the coming edge, queue it, then move to
    // the next falling edge where new inputs may be driven.
    task automatic commit();
        ex_t n;
        if (reset || flush) begin
            n = bubble();
        end else if (stall) begin
            n   = m;
            n.a = fwd(m.a, m.ra);
            n.b = fwd(m.b, m.rb);
        end else if (!id_valid) begin
            n = bubble();
        end else begin
            n.a = fwd(64'(id_rA_data), f_ra);
            n.b = fwd(64'(id_rB_data), f_rb);
            n.op = f_op; n.fn = f_fn; n.ww = f_ww; n.rd = f_rd; n.ppp = f_ppp;
            n.ra = f_ra; n.rb = f_rb; n.valid = 1'b1;
            n.wr = (f_op == 6'b101010 && f_fn != 6'b000000) || f_op == 6'b100000;
        end
        m = n;
        exp_q.push_back(n);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor: compare every registered output just after each edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rA_64bit_val !== e.a || rB_64bit_val !== e.b || Op_code !== e.op ||
                R_ins !== e.fn || WW !== e.ww || ex_rd_addr !== e.rd || ex_ppp !== e.ppp ||
                ex_rA_addr !== e.ra || ex_rB_addr !== e.rb || ex_reg_wr !== e.wr ||
                ex_valid !== e.valid) begin
                n_err++;
                $display("FAIL ex_state @%0t: got a=%h b=%h op=%h fn=%h ww=%h rd=%h ppp=%h ra=%h rb=%h wr=%b v=%b, expected a=%h b=%h op=%h fn=%h ww=%h rd=%h ppp=%h ra=%h rb=%h wr=%b v=%b",
                         $time, rA_64bit_val, rB_64bit_val, Op_code, R_ins, WW, ex_rd_addr,
                         ex_ppp, ex_rA_addr, ex_rB_addr, ex_reg_wr, ex_valid,
                         e.a, e.b, e.op, e.fn, e.ww, e.rd, e.ppp, e.ra, e.rb, e.wr, e.valid);
            end
        end
    end

    initial begin
        m = bubble();
        reset = 1'b1; id_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        wb_reg_wr = 1'b0; wb_rd_addr = '0; wb_ppp = '0; wb_data = '0;
        id_rA_data = 64'h0123_4567_89AB_CDEF; id_rB_data = 64'hFEDC_BA98_7654_3210;
        set_instr(6'b101010, 5'd7, 5'd1, 5'd2, 3'd0, 2'b11, 6'b000110);

        // Reset held two cycles with a valid instruction present
        commit();
        commit();
        check("reset_valid", 64'(ex_valid), 64'd0);
        check("reset_rA", 64'(rA_64bit_val), 64'd0);
        reset = 1'b0;

        // Plain load
        set_instr(6'b101010, 5'd3, 5'd1, 5'd2, 3'b000, 2'b10, 6'b000110);
        id_rA_data = 64'hFFFFFFFF_00000000;
        id_rB_data = 64'h00000000_11111111;
        commit();
        check("load_rA", 64'(rA_64bit_val), 64'hFFFFFFFF_00000000);
        check("load_rB", 64'(rB_64bit_val), 64'h00000000_11111111);
        check("load_R_ins", 64'(R_ins), 64'h06);
        check("load_WW", 64'(WW), 64'h2);
        check("load_reg_wr", 64'(ex_reg_wr), 64'd1);
        check("load_rd", 64'(ex_rd_addr), 64'd3);

        // Partial forwarding into rA
        wb_reg_wr = 1'b1; wb_rd_addr = 5'd1; wb_ppp = 3'b001;
        wb_data = 64'hAAAAAAAA_BBBBBBBB; id_rA_data = 64'h11111111_22222222;
        commit();
        check("fwd_ppp001", 64'(rA_64bit_val), 64'hAAAAAAAA_22222222);
        wb_ppp = 3'b011;
        commit();
        check("fwd_ppp011", 64'(rA_64bit_val), 64'hAA11AA11_BB22BB22);

        // Stall-time forwarding into held rB = R2
        wb_reg_wr = 1'b0; id_rB_data = 64'd5;
        commit();
        stall = 1'b1;
        set_instr(6'b100000, 5'd9, 5'd4, 5'd5, 3'd2, 2'b01, 6'b010010);
        id_rA_data = 64'hDEAD; id_rB_data = 64'hBEEF;
        commit();
        check("stall1_rB", 64'(rB_64bit_val), 64'd5);
        wb_reg_wr = 1'b1; wb_rd_addr = 5'd2; wb_ppp = 3'b000; wb_data = 64'd20;
        commit();
        check("stall2_rB", 64'(rB_64bit_val), 64'd20);
        check("stall2_R_ins", 64'(R_ins), 64'h06);
        wb_reg_wr = 1'b0;
        commit();
        check("stall3_rB", 64'(rB_64bit_val), 64'd20);
        stall = 1'b0;
        commit();
        check("release_op", 64'(Op_code), 64'h20);

        // Flush beats stall
        flush = 1'b1; stall = 1'b1;
        commit();
        check("flush_valid", 64'(ex_valid), 64'd0);
        check("flush_reg_wr", 64'(ex_reg_wr), 64'd0);
        flush = 1'b0; stall = 1'b0;

        // Non-writing R-type and invalid slot
        set_instr(6'b101010, 5'd4, 5'd1, 5'd2, 3'd0, 2'b00, 6'b000000);
        commit();
        check("nop_reg_wr", 64'(ex_reg_wr), 64'd0);
        check("nop_valid", 64'(ex_valid), 64'd1);
        id_valid = 1'b0;
        commit();
        check("bubble_valid", 64'(ex_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            case ($urandom_range(0, 3))
                0, 1:    op = 6'b101010;
                2:       op = 6'b100000;
                default: op = 6'($urandom);
            endcase
            fn = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
            set_instr(op, 5'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      3'($urandom), 2'($urandom), fn);
            id_rA_data = {$urandom, $urandom};
            id_rB_data = {$urandom, $urandom};
            wb_data    = {$urandom, $urandom};
            wb_reg_wr  = ($urandom_range(0, 1) == 1);
            wb_rd_addr = 5'($urandom_range(0, 3));
            wb_ppp     = 3'($urandom);
            id_valid   = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            reset      = ($urandom_range(0, 29) == 0);
            commit();
        end

        reset = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b0; wb_reg_wr = 1'b0;
        commit();
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
